// File: rtl/jbi_cmp_clk_seq_pkg.sv
// Shared definitions for the CMP clock-cluster header sequencer.
// - seq_state_e : sequencer states (OFF, WARM, RST, RUN, DBG, DRAIN)
// - Def*        : default parameter values for the phase lengths
// - seq_out_t   : bundle of header/status outputs
// - seq_decode  : per-state output decode
// - cyc_in_range: legality check for a phase length against the counter width
package jbi_cmp_clk_seq_pkg;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StWarm  = 3'd1,
        StRst   = 3'd2,
        StRun   = 3'd3,
        StDbg   = 3'd4,
        StDrain = 3'd5
    } seq_state_e;

    localparam int unsigned DefCntW      = 8;
    localparam int unsigned DefSettleCyc = 16;
    localparam int unsigned DefGrstCyc   = 32;
    localparam int unsigned DefDbgCyc    = 8;
    localparam int unsigned DefStopCyc   = 4;

    typedef struct packed {
        logic cken;
        logic grst_l;
        logic gdbginit_l;
        logic running;
        logic busy;
    } seq_out_t;

    function automatic seq_out_t seq_decode(seq_state_e st);
        seq_out_t o;
        o = '0;
        case (st)
            StWarm:  begin o.cken = 1'b1; o.busy = 1'b1; end
            StRst:   begin o.cken = 1'b1; o.busy = 1'b1; end
            StRun:   begin
                o.cken       = 1'b1;
                o.grst_l     = 1'b1;
                o.gdbginit_l = 1'b1;
                o.running    = 1'b1;
            end
            StDbg:   begin o.cken = 1'b1; o.grst_l = 1'b1; o.busy = 1'b1; end
            StDrain: begin o.cken = 1'b1; o.busy = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // A phase of N cycles loads N-1, so N may be as large as 2^cnt_w.
    function automatic bit cyc_in_range(int unsigned cyc, int unsigned cnt_w);
        return (cyc >= 1) && (cyc <= (32'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/jbi_cmp_seq_cnt.sv
// Loadable down-counter used to time the sequencer phases.
// - clk_i      : clock
// - rst_i      : asynchronous active-high reset (counter to zero)
// - load_i     : load load_val_i this cycle (has priority over decrement)
// - load_val_i : value to load
// - zero_o     : counter currently holds zero
// Decrement stops at zero so an idle counter never wraps.
module jbi_cmp_seq_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jbi_cmp_clk_seq.sv
// Power-up / debug-init / shutdown sequencer for the CMP clock-cluster header.
// - gclk         : free-running global clock
// - arst         : asynchronous active-high reset
// - start_req    : one-cycle request to power the cluster up
// - stop_req     : one-cycle request to shut the cluster down
// - dbg_req      : one-cycle request for a debug-init pulse
// - cluster_cken : cluster clock enable
// - grst_l       : active-low cluster reset
// - gdbginit_l   : active-low cluster debug init
// - running      : high in RUN
// - busy         : high in WARM, RST, DBG, DRAIN
// The clock is enabled for SETTLE_CYC cycles before the reset-hold phase and reset is
// reasserted for STOP_CYC cycles before the clock is gated. Outputs are registered from
// the next state, so they change exactly with the state and never depend on the
// request inputs combinationally.
module jbi_cmp_clk_seq
    import jbi_cmp_clk_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned SETTLE_CYC = DefSettleCyc,
    parameter int unsigned GRST_CYC   = DefGrstCyc,
    parameter int unsigned DBG_CYC    = DefDbgCyc,
    parameter int unsigned STOP_CYC   = DefStopCyc
) (
    input  logic gclk,
    input  logic arst,
    input  logic start_req,
    input  logic stop_req,
    input  logic dbg_req,
    output logic cluster_cken,
    output logic grst_l,
    output logic gdbginit_l,
    output logic running,
    output logic busy
);

    localparam bit ParamsOk = cyc_in_range(SETTLE_CYC, CNT_W) && cyc_in_range(GRST_CYC, CNT_W)
                           && cyc_in_range(DBG_CYC, CNT_W) && cyc_in_range(STOP_CYC, CNT_W);

    if (!ParamsOk) begin : g_bad_params
        $error("jbi_cmp_clk_seq: every *_CYC must lie in 1 .. 2**CNT_W");
    end

    seq_state_e       state_q, state_d;
    seq_out_t         out_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    jbi_cmp_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i      (gclk),
        .rst_i      (arst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    // Next state. stop_req outranks dbg_req, which outranks start_req; requests a state
    // does not act on are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff: begin
                if (start_req) state_d = StWarm;
            end
            StWarm: begin
                if (stop_req)      state_d = StDrain;
                else if (cnt_zero) state_d = StRst;
            end
            StRst: begin
                if (stop_req)      state_d = StDrain;
                else if (cnt_zero) state_d = StRun;
            end
            StRun: begin
                if (stop_req)     state_d = StDrain;
                else if (dbg_req) state_d = StDbg;
            end
            StDbg: begin
                if (stop_req)      state_d = StDrain;
                else if (cnt_zero) state_d = StRun;
            end
            StDrain: begin
                if (cnt_zero) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    // No state loops to itself, so a change of state marks a phase entry.
    always_comb begin
        cnt_load     = (state_d != state_q);
        cnt_load_val = '0;
        case (state_d)
            StWarm:  cnt_load_val = CNT_W'(SETTLE_CYC - 1);
            StRst:   cnt_load_val = CNT_W'(GRST_CYC - 1);
            StDbg:   cnt_load_val = CNT_W'(DBG_CYC - 1);
            StDrain: cnt_load_val = CNT_W'(STOP_CYC - 1);
            default: cnt_load_val = '0;
        endcase
    end

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q <= StOff;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= seq_decode(state_d);
        end
    end

    assign cluster_cken = out_q.cken;
    assign grst_l       = out_q.grst_l;
    assign gdbginit_l   = out_q.gdbginit_l;
    assign running      = out_q.running;
    assign busy         = out_q.busy;

endmodule

// File: tb/tb_jbi_cmp_clk_seq.sv
// Bench for jbi_cmp_clk_seq with default parameters: a phase-timeline model checked
// every cycle, plus directed literal checks at hand-computed cycle numbers.
module tb_jbi_cmp_clk_seq;

    localparam int P_OFF   = 0;
    localparam int P_WARM  = 1;
    localparam int P_RST   = 2;
    localparam int P_RUN   = 3;
    localparam int P_DBG   = 4;
    localparam int P_DRAIN = 5;

    logic gclk;
    logic arst;
    logic start_req, stop_req, dbg_req;
    logic cluster_cken, grst_l, gdbginit_l, running, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    int m_ph   = P_OFF;
    int m_left = 0;

    jbi_cmp_clk_seq dut (
        .gclk         (gclk),
        .arst         (arst),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .dbg_req      (dbg_req),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .running      (running),
        .busy         (busy)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    always @(posedge gclk) if (!arst) cyc <= cyc + 1;

    // Phase lengths in cycles with the default parameters.
    function automatic int phase_len(int ph);
        case (ph)
            P_WARM:  return 16;
            P_RST:   return 32;
            P_DBG:   return 8;
            P_DRAIN: return 4;
            default: return 0;
        endcase
    endfunction

    // left = cycles remaining in the current phase including this one.
    function automatic int next_phase(int ph, int left, logic st, logic sp, logic dg);
        if (ph == P_OFF)   return st ? P_WARM : P_OFF;
        if (ph == P_DRAIN) return (left == 1) ? P_OFF : P_DRAIN;
        if (sp)            return P_DRAIN;
        if (ph == P_RUN)   return dg ? P_DBG : P_RUN;
        if (left == 1)     return (ph == P_WARM) ? P_RST : P_RUN;
        return ph;
    endfunction

    // {cken, grst_l, gdbginit_l, running, busy}
    function automatic logic [4:0] exp_out(int ph);
        case (ph)
            P_WARM:  return 5'b10001;
            P_RST:   return 5'b10001;
            P_RUN:   return 5'b11110;
            P_DBG:   return 5'b11001;
            P_DRAIN: return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    always @(posedge gclk or posedge arst) begin
        if (arst) begin
            m_ph   <= P_OFF;
            m_left <= 0;
        end else if (next_phase(m_ph, m_left, start_req, stop_req, dbg_req) != m_ph) begin
            m_ph   <= next_phase(m_ph, m_left, start_req, stop_req, dbg_req);
            m_left <= phase_len(next_phase(m_ph, m_left, start_req, stop_req, dbg_req));
        end else begin
            m_left <= m_left - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    always @(negedge gclk) begin
        if (cmp_en && !arst) begin
            check("model_cmp", {27'd0, cluster_cken, grst_l, gdbginit_l, running, busy},
                  {27'd0, exp_out(m_ph)});
        end
    end

    // Returns 1 time unit after the posedge that starts cycle n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge gclk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        arst = 1'b1; start_req = 1'b0; stop_req = 1'b0; dbg_req = 1'b0;
        #12;
        check("rst_cken", cluster_cken, 0);
        check("rst_grst", grst_l, 0);
        check("rst_dbg", gdbginit_l, 0);
        check("rst_running", running, 0);
        check("rst_busy", busy, 0);
        #11 arst = 1'b0;
        cmp_en = 1'b1;

        // Power-up
        goto(10);
        check("pwr_cken10", cluster_cken, 0);
        start_req = 1'b1;
        goto(11);
        start_req = 1'b0;
        check("pwr_cken11", cluster_cken, 1);
        check("pwr_grst11", grst_l, 0);
        goto(58);
        check("pwr_grst58", grst_l, 0);
        check("pwr_busy58", busy, 1);
        goto(59);
        check("pwr_grst59", grst_l, 1);
        check("pwr_dbg59", gdbginit_l, 1);
        check("pwr_run59", running, 1);
        check("model_pin_run59", m_ph, P_RUN);

        // Debug init, second request mid-pulse ignored
        goto(70);
        dbg_req = 1'b1;
        goto(71);
        dbg_req = 1'b0;
        check("dbg_low71", gdbginit_l, 0);
        check("dbg_cken71", cluster_cken, 1);
        check("dbg_grst71", grst_l, 1);
        goto(74);
        dbg_req = 1'b1;
        goto(75);
        dbg_req = 1'b0;
        goto(78);
        check("dbg_low78", gdbginit_l, 0);
        goto(79);
        check("dbg_high79", gdbginit_l, 1);
        check("dbg_run79", running, 1);
        goto(82);
        check("dbg_noq82", gdbginit_l, 1);

        // Priority: stop and dbg together
        goto(90);
        stop_req = 1'b1; dbg_req = 1'b1;
        goto(91);
        stop_req = 1'b0; dbg_req = 1'b0;
        check("prio_grst91", grst_l, 0);
        check("prio_busy91", busy, 1);
        check("model_pin_drain91", m_ph, P_DRAIN);
        goto(94);
        check("prio_cken94", cluster_cken, 1);
        goto(95);
        check("prio_cken95", cluster_cken, 0);
        check("prio_busy95", busy, 0);

        // Plain shutdown
        goto(100);
        start_req = 1'b1;
        goto(101);
        start_req = 1'b0;
        goto(149);
        check("sd_run149", running, 1);
        goto(155);
        stop_req = 1'b1;
        goto(156);
        stop_req = 1'b0;
        check("sd_grst156", grst_l, 0);
        check("sd_cken156", cluster_cken, 1);
        goto(159);
        check("sd_cken159", cluster_cken, 1);
        goto(160);
        check("sd_cken160", cluster_cken, 0);
        check("sd_busy160", busy, 0);

        // Abort during WARM, start during DRAIN dropped
        goto(170);
        start_req = 1'b1;
        goto(171);
        start_req = 1'b0;
        goto(175);
        stop_req = 1'b1;
        goto(176);
        stop_req = 1'b0;
        check("ab_grst176", grst_l, 0);
        check("ab_busy176", busy, 1);
        goto(177);
        start_req = 1'b1;
        goto(178);
        start_req = 1'b0;
        goto(179);
        check("ab_cken179", cluster_cken, 1);
        goto(180);
        check("ab_cken180", cluster_cken, 0);
        goto(185);
        check("ab_off185", cluster_cken, 0);
        check("model_pin_off185", m_ph, P_OFF);

        // Async reset in the middle of DBG
        goto(190);
        start_req = 1'b1;
        goto(191);
        start_req = 1'b0;
        goto(245);
        dbg_req = 1'b1;
        goto(246);
        dbg_req = 1'b0;
        goto(248);
        check("ar_dbg248", gdbginit_l, 0);
        #2 arst = 1'b1;
        #1;
        check("ar_cken", cluster_cken, 0);
        check("ar_grst", grst_l, 0);
        check("ar_dbg", gdbginit_l, 0);
        check("ar_running", running, 0);
        check("ar_busy", busy, 0);
        @(negedge gclk);
        @(negedge gclk);
        arst = 1'b0;
        goto(cyc + 20);
        check("ar_stay_cken", cluster_cken, 0);
        check("ar_stay_busy", busy, 0);
        check("ar_stay_grst", grst_l, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
